// File: rtl/button_event_decoder_if.sv
// Button event bus: debounced button level and edge pulses into the decoder,
// user-intent event pulses and the holding level back out.
interface button_event_decoder_if;
   logic pb_state;
   logic pb_down;
   logic pb_up;
   logic short_press;
   logic long_press;
   logic repeat_pulse;
   logic double_press;
   logic holding;

   modport master (
      output pb_state, pb_down, pb_up,
      input  short_press, long_press, repeat_pulse, double_press, holding
   );

   modport slave (
      input  pb_state, pb_down, pb_up,
      output short_press, long_press, repeat_pulse, double_press, holding
   );
endinterface

// File: rtl/button_event_decoder.sv
// Converts debounced push-button edges into short/long/repeat events as registered pulses.
// Define DOUBLE_CLICK_EN to add the GAP/SECOND states and the double_press event.
module button_event_decoder #(
   parameter int TICK_DIV     = 50000,
   parameter int LONG_TICKS   = 500,
   parameter int REPEAT_TICKS = 100,
   parameter int GAP_TICKS    = 250
) (
   input logic                   clk,
   input logic                   rst,
   button_event_decoder_if.slave bus
);

   localparam int              PW          = $clog2(TICK_DIV);
   localparam logic [PW-1:0]   PRESC_LAST  = PW'(TICK_DIV - 1);
   localparam logic [15:0]     LONG_LAST   = 16'(LONG_TICKS - 1);
   localparam logic [15:0]     REPEAT_LAST = 16'(REPEAT_TICKS - 1);
`ifdef DOUBLE_CLICK_EN
   localparam logic [15:0]     GAP_LAST    = 16'(GAP_TICKS - 1);
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRESSED,
      S_LONG_HELD,
`ifdef DOUBLE_CLICK_EN
      S_GAP,
      S_SECOND,
`endif
      S_WAIT_RELEASE
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [PW-1:0] presc;
   logic [15:0]   ticks;
   logic          first_cycle;

   logic edge_seen;
   logic down_only;
   logic up_only;
   logic tick;
   logic tick_ok;
   logic at_long;
   logic at_repeat;

   logic ev_short;
   logic ev_long;
   logic ev_repeat;
   logic short_q;
   logic long_q;
   logic repeat_q;

`ifdef DOUBLE_CLICK_EN
   logic at_gap;
   logic ev_double;
   logic double_q;
`endif

   assign edge_seen = bus.pb_down | bus.pb_up;
   assign down_only = bus.pb_down & ~bus.pb_up;
   assign up_only   = bus.pb_up & ~bus.pb_down;
   assign tick      = (presc == PRESC_LAST);
   // An edge restarts the timebase, so a coincident tick never drives a timeout.
   assign tick_ok   = tick & ~edge_seen;
   assign at_long   = tick_ok && (ticks == LONG_LAST);
   assign at_repeat = tick_ok && (ticks == REPEAT_LAST);
`ifdef DOUBLE_CLICK_EN
   assign at_gap    = tick_ok && (ticks == GAP_LAST);
`endif

   // Tick phase and tick count are both referenced to the most recent button edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
         ticks <= '0;
      end else begin
         if (edge_seen || tick) begin
            presc <= '0;
         end else begin
            presc <= presc + 1'b1;
         end
         if (edge_seen || ev_long || ev_repeat) begin
            ticks <= '0;
         end else if (tick && (ticks != 16'hFFFF)) begin
            ticks <= ticks + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         first_cycle <= 1'b1;
         short_q     <= 1'b0;
         long_q      <= 1'b0;
         repeat_q    <= 1'b0;
`ifdef DOUBLE_CLICK_EN
         double_q    <= 1'b0;
`endif
      end else begin
         state       <= state_next;
         first_cycle <= 1'b0;
         short_q     <= ev_short;
         long_q      <= ev_long;
         repeat_q    <= ev_repeat;
`ifdef DOUBLE_CLICK_EN
         double_q    <= ev_double;
`endif
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            // A button already held when reset lifts must be released before it counts.
            if (down_only) begin
               state_next = S_PRESSED;
            end else if (first_cycle && bus.pb_state) begin
               state_next = S_WAIT_RELEASE;
            end
         end
         S_PRESSED: begin
            if (up_only) begin
`ifdef DOUBLE_CLICK_EN
               state_next = S_GAP;
`else
               state_next = S_IDLE;
`endif
            end else if (at_long) begin
               state_next = S_LONG_HELD;
            end
         end
         S_LONG_HELD: begin
            if (up_only) begin
               state_next = S_IDLE;
            end
         end
`ifdef DOUBLE_CLICK_EN
         S_GAP: begin
            if (down_only) begin
               state_next = S_SECOND;
            end else if (at_gap) begin
               state_next = S_IDLE;
            end
         end
         S_SECOND: begin
            if (up_only) begin
               state_next = S_IDLE;
            end else if (at_long) begin
               state_next = S_LONG_HELD;
            end
         end
`endif
         S_WAIT_RELEASE: begin
            if (up_only) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      ev_short  = 1'b0;
      ev_long   = 1'b0;
      ev_repeat = 1'b0;
`ifdef DOUBLE_CLICK_EN
      ev_double = 1'b0;
`endif
      case (state)
         S_PRESSED: begin
            if (up_only) begin
`ifndef DOUBLE_CLICK_EN
               ev_short = 1'b1;
`endif
            end else if (at_long) begin
               ev_long = 1'b1;
            end
         end
         S_LONG_HELD: begin
            if (!up_only && at_repeat) begin
               ev_repeat = 1'b1;
            end
         end
`ifdef DOUBLE_CLICK_EN
         S_GAP: begin
            if (!down_only && at_gap) begin
               ev_short = 1'b1;
            end
         end
         S_SECOND: begin
            // Holding the second click into a long press discards the first click.
            if (up_only) begin
               ev_double = 1'b1;
            end else if (at_long) begin
               ev_long = 1'b1;
            end
         end
`endif
         default: begin
         end
      endcase
   end

   assign bus.short_press  = short_q;
   assign bus.long_press   = long_q;
   assign bus.repeat_pulse = repeat_q;
   assign bus.holding      = (state == S_LONG_HELD);
`ifdef DOUBLE_CLICK_EN
   assign bus.double_press = double_q;
`else
   logic unused_gap;
   assign unused_gap       = ^GAP_TICKS;
   assign bus.double_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder: directed scenarios plus random button
// traffic compared cycle by cycle against a time-based behavioural model.
module tb_button_event_decoder;

   localparam int TD = 4;
   localparam int LT = 5;
   localparam int RT = 2;
   localparam int GT = 3;

   localparam int M_IDLE    = 0;
   localparam int M_PRESSED = 1;
   localparam int M_HELD    = 2;
   localparam int M_GAP     = 3;
   localparam int M_SECOND  = 4;
   localparam int M_WAIT    = 5;

`ifdef DOUBLE_CLICK_EN
   localparam int SP_AT  = 23;
   localparam int RST_AT = 75;
`else
   localparam int SP_AT  = 11;
   localparam int RST_AT = 63;
`endif

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   button_event_decoder_if bus ();

   button_event_decoder #(
      .TICK_DIV    (TD),
      .LONG_TICKS  (LT),
      .REPEAT_TICKS(RT),
      .GAP_TICKS   (GT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   int       cyc = 0;
   int       ref_cyc = 0;
   int       m_state = M_IDLE;
   bit       m_first = 1'b0;
   logic [4:0] exp_vec = '0;

   int n_short, n_long, n_rep, n_dbl, n_hold;
   int last_short, long_at, first_rep, last_rep, dbl_at, first_hold, last_hold;

   function automatic logic [4:0] obsVec();
      return {bus.short_press, bus.long_press, bus.repeat_pulse, bus.double_press, bus.holding};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, want %0h", tag, got, want);
      end
   endtask

   // Events fire when exactly N*TD cycles have passed since the timing reference,
   // which is the last button edge or the last long/repeat event.
   task automatic modelStep(input logic r, input logic s, input logic d, input logic u);
      bit ev_s, ev_l, ev_r, ev_d, edg, dn, upk;
      int el;
      ev_s = 0; ev_l = 0; ev_r = 0; ev_d = 0;
      if (r) begin
         m_state = M_IDLE;
         m_first = 1'b1;
         exp_vec = '0;
      end else begin
         edg = d | u;
         dn  = d & ~u;
         upk = u & ~d;
         if (edg) ref_cyc = cyc;
         el = cyc - ref_cyc;
         case (m_state)
            M_IDLE: begin
               if (dn) m_state = M_PRESSED;
               else if (m_first && s) m_state = M_WAIT;
            end
            M_PRESSED: begin
               if (upk) begin
`ifdef DOUBLE_CLICK_EN
                  m_state = M_GAP;
`else
                  m_state = M_IDLE;
                  ev_s = 1;
`endif
               end else if (el == LT * TD) begin
                  m_state = M_HELD; ev_l = 1; ref_cyc = cyc;
               end
            end
            M_HELD: begin
               if (upk) m_state = M_IDLE;
               else if (el == RT * TD) begin
                  ev_r = 1; ref_cyc = cyc;
               end
            end
            M_GAP: begin
               if (dn) m_state = M_SECOND;
               else if (el == GT * TD) begin
                  m_state = M_IDLE; ev_s = 1;
               end
            end
            M_SECOND: begin
               if (upk) begin
                  m_state = M_IDLE; ev_d = 1;
               end else if (el == LT * TD) begin
                  m_state = M_HELD; ev_l = 1; ref_cyc = cyc;
               end
            end
            M_WAIT: begin
               if (upk) m_state = M_IDLE;
            end
            default: m_state = M_IDLE;
         endcase
         m_first = 1'b0;
         exp_vec = {ev_s, ev_l, ev_r, ev_d, (m_state == M_HELD)};
      end
   endtask

   task automatic applyStimulus(input logic r, input logic s, input logic d, input logic u);
      rst          = r;
      bus.pb_state = s;
      bus.pb_down  = d;
      bus.pb_up    = u;
      modelStep(r, s, d, u);
      @(posedge clk);
      #1;
      cyc++;
      checkOutput("events", obsVec(), exp_vec);
   endtask

   task automatic resetTallies();
      n_short = 0; n_long = 0; n_rep = 0; n_dbl = 0; n_hold = 0;
      last_short = -1; long_at = -1; first_rep = -1; last_rep = -1;
      dbl_at = -1; first_hold = -1; last_hold = -1;
   endtask

   // Outputs sampled after the edge that ends cycle rel belong to cycle rel+1.
   task automatic stepLog(input int rel, input logic r, input logic s, input logic d, input logic u);
      applyStimulus(r, s, d, u);
      if (bus.short_press)  begin n_short++; last_short = rel + 1; end
      if (bus.long_press)   begin n_long++;  long_at = rel + 1; end
      if (bus.repeat_pulse) begin
         n_rep++;
         if (first_rep < 0) first_rep = rel + 1;
         last_rep = rel + 1;
      end
      if (bus.double_press) begin n_dbl++; dbl_at = rel + 1; end
      if (bus.holding) begin
         n_hold++;
         if (first_hold < 0) first_hold = rel + 1;
         last_hold = rel + 1;
      end
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int  lvl_left;
      bit  lvl;
      logic r, d, u;

      $display("[TB] starting button_event_decoder bench");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("reset_outputs", obsVec(), 0);
      idleCycles(5);

      resetTallies();
      for (int rel = 0; rel <= 30; rel++) stepLog(rel, 1'b0, rel < 10, rel == 0, rel == 10);
      checkOutput("sp_count", n_short, 1);
      checkOutput("sp_cycle", last_short, SP_AT);
      checkOutput("sp_long", n_long, 0);
      checkOutput("sp_repeat", n_rep, 0);
      checkOutput("sp_double", n_dbl, 0);
      idleCycles(20);

      resetTallies();
      for (int rel = 0; rel <= 50; rel++) stepLog(rel, 1'b0, rel < 40, rel == 0, rel == 40);
      checkOutput("lp_count", n_long, 1);
      checkOutput("lp_cycle", long_at, 21);
      checkOutput("lp_repeats", n_rep, 2);
      checkOutput("lp_rep_first", first_rep, 29);
      checkOutput("lp_rep_last", last_rep, 37);
      checkOutput("lp_hold_len", n_hold, 20);
      checkOutput("lp_hold_rise", first_hold, 21);
      checkOutput("lp_hold_fall", last_hold, 40);
      checkOutput("lp_short", n_short, 0);
      idleCycles(20);

`ifdef DOUBLE_CLICK_EN
      resetTallies();
      for (int rel = 0; rel <= 35; rel++)
         stepLog(rel, 1'b0, (rel < 10) || (rel >= 16 && rel < 20),
                 (rel == 0) || (rel == 16), (rel == 10) || (rel == 20));
      checkOutput("dp_count", n_dbl, 1);
      checkOutput("dp_cycle", dbl_at, 21);
      checkOutput("dp_short", n_short, 0);
      idleCycles(20);
`endif

      resetTallies();
      for (int rel = 0; rel <= 90; rel++)
         stepLog(rel, rel <= 2, (rel <= 50) || (rel >= 60 && rel < 62),
                 rel == 60, (rel == 51) || (rel == 62));
      checkOutput("rh_long", n_long, 0);
      checkOutput("rh_hold", n_hold, 0);
      checkOutput("rh_short", n_short, 1);
      checkOutput("rh_short_cycle", last_short, RST_AT);
      idleCycles(10);

      resetTallies();
      for (int rel = 0; rel <= 45; rel++) begin
         stepLog(rel, rel == 15, rel < 30, rel == 0, rel == 30);
         if (rel == 15) checkOutput("rm_outputs_c16", obsVec(), 0);
      end
      checkOutput("rm_long", n_long, 0);
      checkOutput("rm_short", n_short, 0);
      checkOutput("rm_hold", n_hold, 0);
      idleCycles(10);

      lvl = 1'b0;
      lvl_left = 5;
      for (int i = 0; i < 4000; i++) begin
         r = ($urandom_range(0, 399) == 0);
         d = 1'b0;
         u = 1'b0;
         if (lvl_left == 0) begin
            lvl = ~lvl;
            if (lvl) d = 1'b1;
            else     u = 1'b1;
            if (lvl) lvl_left = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 15) : $urandom_range(18, 60);
            else     lvl_left = $urandom_range(1, 30);
         end else begin
            lvl_left--;
         end
         if ($urandom_range(0, 59) == 0) d = 1'b1;
         if ($urandom_range(0, 59) == 0) u = 1'b1;
         applyStimulus(r, lvl, d, u);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
